// File: rtl/fp16_result_collector.sv
// Result FIFO behind the FP16 adder: tags each accepted result with its IEEE-754 class
// and keeps sticky exception flags plus a saturating count of dropped results.
module fp16_result_collector #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_res_vld,
  input  logic [15:0]              i_res,
  input  logic                     i_overflow,
  input  logic                     i_rdy,
  input  logic                     i_clr_sticky,
  output logic                     o_vld,
  output logic [15:0]              o_data,
  output logic [2:0]               o_class,
  output logic                     o_ovf,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic [CNT_W-1:0]         o_drop_cnt,
  output logic                     o_sticky_ovf,
  output logic                     o_sticky_nan
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [2:0] ClsZero = 3'd0;
  localparam logic [2:0] ClsSub  = 3'd1;
  localparam logic [2:0] ClsNorm = 3'd2;
  localparam logic [2:0] ClsInf  = 3'd3;
  localparam logic [2:0] ClsNan  = 3'd4;

  logic [19:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q, count_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic           sticky_ovf_q, sticky_nan_q;
  logic           sticky_ovf_d, sticky_nan_d;

  logic [2:0]     res_class;
  logic           push, pop, drop;
  logic [19:0]    head;

  always_comb begin
    res_class = ClsNorm;
    if (i_res[14:10] == 5'd0) begin
      res_class = (i_res[9:0] == 10'd0) ? ClsZero : ClsSub;
    end else if (i_res[14:10] == 5'd31) begin
      res_class = (i_res[9:0] == 10'd0) ? ClsInf : ClsNan;
    end
  end

  assign o_full = (count_q == (AW + 1)'(DEPTH));
  assign o_vld  = (count_q != '0);
  assign push   = i_res_vld && !o_full;
  // A pop in the same cycle does not make room for a result seen while full.
  assign drop   = i_res_vld && o_full;
  assign pop    = o_vld && i_rdy;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    drop_cnt_d   = drop_cnt_q;
    sticky_ovf_d = sticky_ovf_q;
    sticky_nan_d = sticky_nan_q;
    if (i_clr_sticky) begin
      drop_cnt_d   = '0;
      sticky_ovf_d = 1'b0;
      sticky_nan_d = 1'b0;
    end
    if (drop && (drop_cnt_d != '1)) begin
      drop_cnt_d = drop_cnt_d + 1'b1;
    end
    if (push && (i_overflow || res_class == ClsInf)) begin
      sticky_ovf_d = 1'b1;
    end
    if (push && res_class == ClsNan) begin
      sticky_nan_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_cnt_q   <= '0;
      sticky_ovf_q <= 1'b0;
      sticky_nan_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q      <= count_d;
      drop_cnt_q   <= drop_cnt_d;
      sticky_ovf_q <= sticky_ovf_d;
      sticky_nan_q <= sticky_nan_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {i_overflow, res_class, i_res};
  end

  assign head         = mem[rd_ptr_q];
  assign o_data       = o_vld ? head[15:0]  : 16'd0;
  assign o_class      = o_vld ? head[18:16] : 3'd0;
  assign o_ovf        = o_vld ? head[19]    : 1'b0;
  assign o_count      = count_q;
  assign o_drop_cnt   = drop_cnt_q;
  assign o_sticky_ovf = sticky_ovf_q;
  assign o_sticky_nan = sticky_nan_q;

endmodule

// File: tb/tb_fp16_result_collector.sv
// Scoreboard bench for fp16_result_collector: directed pushes queue expected entries,
// a negedge monitor compares each popped head against the queue.
module tb_fp16_result_collector;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic i_res_vld;
  logic [15:0] i_res;
  logic i_overflow;
  logic i_rdy;
  logic i_clr_sticky;
  logic o_vld;
  logic [15:0] o_data;
  logic [2:0] o_class;
  logic o_ovf;
  logic [$clog2(DEPTH):0] o_count;
  logic o_full;
  logic [CNT_W-1:0] o_drop_cnt;
  logic o_sticky_ovf;
  logic o_sticky_nan;

  int total = 0;
  int bad = 0;
  logic [19:0] sb [$];

  always #5 clk = ~clk;

  fp16_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_res_vld(i_res_vld), .i_res(i_res), .i_overflow(i_overflow),
    .i_rdy(i_rdy), .i_clr_sticky(i_clr_sticky), .o_vld(o_vld), .o_data(o_data),
    .o_class(o_class), .o_ovf(o_ovf), .o_count(o_count), .o_full(o_full),
    .o_drop_cnt(o_drop_cnt), .o_sticky_ovf(o_sticky_ovf), .o_sticky_nan(o_sticky_nan)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next posedge whenever o_vld && i_rdy here.
  always @(negedge clk) begin
    logic [19:0] exp;
    if (rst && o_vld && i_rdy) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got %0h expected nothing", {o_ovf, o_class, o_data});
      end else begin
        exp = sb.pop_front();
        if ({o_ovf, o_class, o_data} !== exp) begin
          bad++;
          $display("FAIL pop_entry: got %0h expected %0h", {o_ovf, o_class, o_data}, exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic ovf, input logic [2:0] cls,
                      input bit accept);
    i_res_vld  = 1'b1;
    i_res      = d;
    i_overflow = ovf;
    if (accept) sb.push_back({ovf, cls, d});
    step();
    i_res_vld  = 1'b0;
    i_overflow = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    i_rdy = 1'b1;
    while (o_vld && n < 20) begin
      step();
      n++;
    end
    if (o_vld) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got o_vld=1 expected 0");
    end
    i_rdy = 1'b0;
  endtask

  task automatic clear_sticky();
    i_clr_sticky = 1'b1;
    step();
    i_clr_sticky = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    i_res_vld = 1'b0;
    i_res = 16'h0;
    i_overflow = 1'b0;
    i_rdy = 1'b0;
    i_clr_sticky = 1'b0;
    step();
    step();
    check("rst_vld", 32'(o_vld), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_full", 32'(o_full), 32'd0);
    check("rst_drop", 32'(o_drop_cnt), 32'd0);
    check("rst_head", 32'({o_ovf, o_class, o_data}), 32'd0);
    check("rst_sticky", 32'({o_sticky_ovf, o_sticky_nan}), 32'd0);
    rst = 1'b1;
    step();

    // 1: single push with consumer ready
    i_rdy = 1'b1;
    push(16'h4700, 1'b0, 3'd2, 1'b1);
    check("t1_vld", 32'(o_vld), 32'd1);
    check("t1_data", 32'(o_data), 32'h4700);
    check("t1_class", 32'(o_class), 32'd2);
    step();
    check("t1_empty", 32'(o_vld), 32'd0);
    check("t1_empty_data", 32'(o_data), 32'd0);
    i_rdy = 1'b0;

    // 2: one of each special class
    push(16'h0000, 1'b0, 3'd0, 1'b1);
    push(16'h0001, 1'b0, 3'd1, 1'b1);
    push(16'h7C00, 1'b1, 3'd3, 1'b1);
    push(16'h7E00, 1'b0, 3'd4, 1'b1);
    check("t2_count", 32'(o_count), 32'd4);
    check("t2_sticky_ovf", 32'(o_sticky_ovf), 32'd1);
    check("t2_sticky_nan", 32'(o_sticky_nan), 32'd1);
    drain();
    clear_sticky();
    check("t2_clr", 32'({o_sticky_ovf, o_sticky_nan}), 32'd0);

    // 3: overfill by one
    for (int i = 0; i < 9; i++) begin
      push(16'h3C00 + 16'(i), 1'b0, 3'd2, i < 8);
      if (i == 7) check("t3_full", 32'(o_full), 32'd1);
    end
    check("t3_count", 32'(o_count), 32'd8);
    check("t3_drop", 32'(o_drop_cnt), 32'd1);
    check("t3_sticky", 32'({o_sticky_ovf, o_sticky_nan}), 32'd0);
    drain();
    check("t3_drop_kept", 32'(o_drop_cnt), 32'd1);
    clear_sticky();
    check("t3_drop_clr", 32'(o_drop_cnt), 32'd0);

    // 4: steady push+pop at occupancy 3, wrapping pointers
    for (int i = 0; i < 3; i++) push(16'h4000 + 16'(i), 1'b0, 3'd2, 1'b1);
    check("t4_count", 32'(o_count), 32'd3);
    i_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      push(16'h4400 + 16'(i), 1'b0, 3'd2, 1'b1);
      check("t4_count_steady", 32'(o_count), 32'd3);
    end
    drain();

    // 5: reset mid-operation
    for (int i = 0; i < 4; i++) push(16'h4800 + 16'(i), 1'b0, 3'd2, 1'b1);
    push(16'h7E01, 1'b1, 3'd4, 1'b1);
    check("t5_count", 32'(o_count), 32'd5);
    rst = 1'b0;
    step();
    rst = 1'b1;
    sb.delete();
    check("t5_vld", 32'(o_vld), 32'd0);
    check("t5_count_rst", 32'(o_count), 32'd0);
    check("t5_drop", 32'(o_drop_cnt), 32'd0);
    check("t5_sticky", 32'({o_sticky_ovf, o_sticky_nan}), 32'd0);
    i_rdy = 1'b1;
    push(16'h4200, 1'b0, 3'd2, 1'b1);
    check("t5_after_vld", 32'(o_vld), 32'd1);
    drain();

    // 6: push while full with simultaneous pop is still dropped
    for (int i = 0; i < 8; i++) push(16'h5800 + 16'(i), 1'b0, 3'd2, 1'b1);
    check("t6_full", 32'(o_full), 32'd1);
    i_rdy = 1'b1;
    push(16'h5000, 1'b0, 3'd2, 1'b0);
    check("t6_drop", 32'(o_drop_cnt), 32'd1);
    check("t6_count", 32'(o_count), 32'(DEPTH - 1));
    drain();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
